// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, parser state type and status-type helper.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;

  localparam logic [6:0] CC_ATTACK = 7'd73;
  localparam logic [6:0] CC_DECAY  = 7'd72;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SKIP
  } parse_state_t;

  function automatic logic is_supported_type(input logic [3:0] t);
    return t inside {NOTE_OFF, NOTE_ON, CTRL, PROG};
  endfunction

endpackage

// File: rtl/midi_note_stack.sv
// rtl/midi_note_stack.sv - last-note-priority held-note stack, built only with MIDI_NOTE_STACK_EN.
`ifdef MIDI_NOTE_STACK_EN
module midi_note_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_en,
  input  logic [6:0] push_note,
  input  logic       rm_en,
  input  logic [6:0] rm_note,
  output logic       busy,
  output logic [6:0] top,
  output logic       empty
);

  localparam int CW = 4;

  logic [6:0]    ent [DEPTH];
  logic [6:0]    nxt [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic          rm_pending;
  logic [6:0]    rm_held;
  logic [6:0]    key;
  logic          hit;
  logic [CW-1:0] hit_idx;
  logic [CW-1:0] del_idx;

  // ent[cnt-1] is the newest note; removal/move shifts newer entries down by one.
  always_comb begin
    key     = rm_pending ? rm_held : push_note;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt && ent[i] == key) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
    del_idx = hit ? hit_idx : '0;
    nxt     = ent;
    nxt_cnt = cnt;
    if (rm_pending) begin
      if (hit) begin
        for (int i = 0; i < DEPTH - 1; i++)
          if (CW'(i) >= del_idx) nxt[i] = ent[i + 1];
        nxt_cnt = cnt - CW'(1);
      end
    end else if (push_en) begin
      if (hit || cnt == CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH - 1; i++)
          if (CW'(i) >= del_idx) nxt[i] = ent[i + 1];
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt - CW'(1)) nxt[i] = push_note;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt) nxt[i] = push_note;
        nxt_cnt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      cnt        <= '0;
      rm_pending <= 1'b0;
      rm_held    <= '0;
    end else begin
      ent        <= nxt;
      cnt        <= nxt_cnt;
      rm_pending <= rm_en;
      if (rm_en) rm_held <= rm_note;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (cnt != '0 && CW'(i) == cnt - CW'(1)) top = ent[i];
  end

  assign empty = (cnt == '0);
  assign busy  = rm_pending;

endmodule
`endif

// File: rtl/midi_voice_ctrl.sv
// rtl/midi_voice_ctrl.sv - MIDI byte-stream parser driving monophonic voice controls.
// Optional held-note stack enabled by MIDI_NOTE_STACK_EN.
module midi_voice_ctrl
  import midi_pkg::*;
#(
  parameter int         CHANNEL        = 0,
  parameter logic [7:0] DEFAULT_ATTACK = 8'h10,
  parameter logic [7:0] DEFAULT_DECAY  = 8'h20,
  parameter int         STACK_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [6:0] note,
  output logic       gate,
  output logic       note_strobe,
  output logic [3:0] voice_select,
  output logic [7:0] envelope_attack,
  output logic [7:0] envelope_decay
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  parse_state_t state;
  logic [3:0]   run_type;
  logic [6:0]   d1;
  logic         accept;
  logic         is_status;
  logic         is_realtime;
  logic         msg_done;
  logic         push_en;
  logic         rm_en;
  logic [6:0]   d2;

  assign accept      = byte_valid && byte_ready;
  assign is_status   = byte_in[7];
  assign is_realtime = &byte_in[7:3];
  assign d2          = byte_in[6:0];
  assign msg_done    = accept && !is_status && state == ST_WAIT_D2;
  assign push_en     = msg_done && run_type == NOTE_ON && d2 != 7'd0;
  assign rm_en       = msg_done && (run_type == NOTE_OFF || (run_type == NOTE_ON && d2 == 7'd0));

`ifdef MIDI_NOTE_STACK_EN
  logic stk_busy;
  logic stk_empty;

  midi_note_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push_en  (push_en),
    .push_note(d1),
    .rm_en    (rm_en),
    .rm_note  (d1),
    .busy     (stk_busy),
    .top      (note),
    .empty    (stk_empty)
  );

  assign gate       = !stk_empty;
  assign byte_ready = !stk_busy;
`else
  logic [6:0] note_r;
  logic       gate_r;

  assign note       = note_r;
  assign gate       = gate_r;
  assign byte_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      run_type        <= 4'h0;
      d1              <= '0;
      note_strobe     <= 1'b0;
      voice_select    <= '0;
      envelope_attack <= DEFAULT_ATTACK;
      envelope_decay  <= DEFAULT_DECAY;
`ifndef MIDI_NOTE_STACK_EN
      note_r          <= '0;
      gate_r          <= 1'b0;
`endif
    end else begin
      note_strobe <= push_en;
      // Realtime bytes are invisible to the parser: no state or running-status change.
      if (accept && !is_realtime) begin
        if (is_status) begin
          if (byte_in[7:4] != 4'hF && byte_in[3:0] == CH && is_supported_type(byte_in[7:4])) begin
            run_type <= byte_in[7:4];
            state    <= ST_WAIT_D1;
          end else begin
            state <= ST_SKIP;
          end
        end else begin
          case (state)
            ST_WAIT_D1: begin
              if (run_type == PROG) begin
                voice_select <= byte_in[3:0];
              end else begin
                d1    <= d2;
                state <= ST_WAIT_D2;
              end
            end
            ST_WAIT_D2: begin
              state <= ST_WAIT_D1;
              if (run_type == CTRL) begin
                if (d1 == CC_ATTACK) envelope_attack <= {d2, d2[6]};
                if (d1 == CC_DECAY)  envelope_decay  <= {d2, d2[6]};
              end
            end
            default: ;
          endcase
        end
      end
`ifndef MIDI_NOTE_STACK_EN
      if (push_en) begin
        note_r <= d1;
        gate_r <= 1'b1;
      end else if (rm_en && d1 == note_r) begin
        gate_r <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/midi_voice_ctrl.md
Name: midi_voice_ctrl

Overview:
- Front end for the synth voice: parses a serial MIDI byte stream and drives the voice control inputs.
- Voice control inputs driven: note, gate, voice_select, envelope_attack, envelope_decay.
- Byte stream source: the UART receiver, via a valid/ready byte handshake.
- Monophonic, single MIDI channel.
- Supported messages: Note On, Note Off, Program Change, and Control Change for the attack and decay envelope times.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) this voice responds to.
- DEFAULT_ATTACK, 8'h10, envelope_attack value after reset.
- DEFAULT_DECAY, 8'h20, envelope_decay value after reset.
- STACK_DEPTH, 4, held-note stack entries. Used only with MIDI_NOTE_STACK_EN; range 2-8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- byte_in  in  8  received MIDI byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  block accepts byte_in this cycle
- note  out  7  current MIDI note number
- gate  out  1  high while the current note is held
- note_strobe  out  1  one-cycle pulse on every accepted Note On (retrigger)
- voice_select  out  4  waveform select, from Program Change
- envelope_attack  out  8  attack time, from CC 73
- envelope_decay  out  8  decay time, from CC 72

Behaviour:
- Byte transfer: a byte is accepted when byte_valid && byte_ready.
- byte_ready is 1 except during the single stack-compaction cycle (optional feature only).
- Reset values (rst low, asynchronous): note=0, gate=0, note_strobe=0, voice_select=0, envelope_attack=DEFAULT_ATTACK, envelope_decay=DEFAULT_DECAY, byte_ready=1. Parser state is IDLE with no running status.
- Realtime bytes 0xF8-0xFF: ignored in every state. They change neither state nor running status.
- Parser states:
  - IDLE: no running status. Data bytes (bit7=0) are dropped.
  - WAIT_D1: status held, awaiting the first data byte.
  - WAIT_D2: first data byte held, awaiting the second.
  - SKIP: unsupported or other-channel status. Data bytes are dropped until the next status byte.
- Status byte 0x80-0xEF:
  - Channel nibble equals CHANNEL and type is 0x8/0x9/0xB/0xC: latch as running status, go to WAIT_D1.
  - Otherwise: go to SKIP.
- Status byte 0xF0-0xF7: clears running status, go to SKIP.
- A status byte arriving in WAIT_D1 or WAIT_D2 abandons the partial message. The new status is processed normally.
- 0xC (Program Change) is a one-data-byte message: voice_select <= d1[3:0]. Stay in WAIT_D1 (running status).
- Two-byte messages complete in WAIT_D2, then return to WAIT_D1 (running status).
- Message decode:
  - Note On with velocity > 0: note <= d1, gate <= 1, note_strobe pulses.
  - Note On with velocity = 0: treated as Note Off.
  - Note Off (d1 == note): gate <= 0.
  - Note Off (d1 != note): ignored.
  - CC 73: envelope_attack <= {d2[6:0], d2[6]}.
  - CC 72: envelope_decay <= {d2[6:0], d2[6]}.
  - Other CC numbers: ignored.
- Latency: outputs are registered and update on the clock edge after the final data byte is accepted. note_strobe is high for exactly that one cycle.
- Back-to-back Note On messages keep gate=1. Each one updates note and pulses note_strobe.
- Reset asserted mid-message: the partial message is lost and all outputs return to reset values immediately.

Optional Feature:
- Macro: MIDI_NOTE_STACK_EN.
- With the macro, last-note-priority stack of STACK_DEPTH entries:
  - Note On pushes the note. If the note is already present, it moves to the top. If the stack is full, the oldest entry is discarded.
  - Note Off removes the matching entry. Compaction takes one cycle, with byte_ready=0 during that cycle.
  - Outputs follow the stack top: note = top entry.
  - Removing the top leaves note = new top and gate=1, with no note_strobe.
  - gate=0 only when the stack becomes empty.
- Without the macro: single-note behaviour as in Behaviour, and byte_ready is tied to 1.

Decomposition:
- Shared package midi_pkg:
  - Status type constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB, PROG=4'hC.
  - CC numbers: CC_ATTACK=73, CC_DECAY=72.
  - Parser state enum.
- Sub-module midi_note_stack: push / remove / top / empty, compiled only under MIDI_NOTE_STACK_EN.

Test Plan:
- Bytes 0x90 0x3C 0x64 -> one cycle after the last byte: note=60, gate=1, note_strobe high for 1 cycle. Then 0x80 0x3C 0x40 -> gate=0.
- Running status 0x90 0x40 0x50 0x43 0x50 -> note=64 then note=67, two strobes, gate stays 1. Then 0x43 0x00 -> gate=0.
- 0xF8 inserted between 0x90 and 0x3C, and again between 0x3C and 0x64 -> same result as the plain sequence. Data byte 0x3C with no prior status -> no output change.
- Other channel 0x91 0x3C 0x64 -> no change. 0xC0 0x05 -> voice_select=5. 0xB0 0x49 0x7F -> envelope_attack=0xFF. 0xB0 0x48 0x00 -> envelope_decay=0x00.
- rst pulsed low after 0x90 0x3C -> outputs at reset values. Subsequent 0x64 is dropped, since there is no running status.
- With MIDI_NOTE_STACK_EN: on 60, on 64, off 64 -> note=60, gate=1, byte_ready low 1 cycle. Off 60 -> gate=0. Five note-ons with depth 4 -> oldest dropped.
